// File: rtl/fmc_adc_serdes_tx_pkg.sv
// Shared types and constants for the 2-lane serial ADC transmitter.
package fmc_adc_serdes_tx_pkg;
  localparam int c_BITS_PER_FRAME = 8;
  localparam int c_SAMPLE_WIDTH   = 14;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_ZERO  = 2'd3
  } t_tx_mode;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } t_tx_state;

  typedef logic [c_SAMPLE_WIDTH-1:0] t_word;
endpackage

// File: rtl/fmc_adc_serdes_tx_if.sv
// Sample-side and serial-side signal bundle of the transmitter.
interface fmc_adc_serdes_tx_if #(
  parameter int NB_CH = 4
);
  logic                   en_i;
  logic [1:0]             mode_i;
  logic [NB_CH-1:0][13:0] sample_i;
  logic                   sample_valid_i;
  logic                   sample_ready_o;
  logic                   fr_o;
  logic [NB_CH-1:0]       outa_o;
  logic [NB_CH-1:0]       outb_o;
  logic [15:0]            underrun_cnt_o;
  logic                   busy_o;

  modport master (
    output en_i, mode_i, sample_i, sample_valid_i,
    input  sample_ready_o, fr_o, outa_o, outb_o, underrun_cnt_o, busy_o
  );

  modport slave (
    input  en_i, mode_i, sample_i, sample_valid_i,
    output sample_ready_o, fr_o, outa_o, outb_o, underrun_cnt_o, busy_o
  );
endinterface

// File: rtl/fmc_adc_pattern_gen.sv
// Internal word source: shared triangle, fixed word or zero.
// word_o already reflects the post-advance triangle value so the caller can
// load it in the same cycle it pulses adv_i.
module fmc_adc_pattern_gen
  import fmc_adc_serdes_tx_pkg::*;
#(
  parameter int          g_TRI_STEP      = 8,
  parameter int          g_TRI_LIMIT     = 400,
  parameter logic [13:0] g_FIXED_PATTERN = 14'h1555
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     adv_i,
  input  t_tx_mode mode_i,
  output t_word    word_o
);
  localparam logic signed [13:0] c_LIM  = 14'(g_TRI_LIMIT);
  localparam logic signed [13:0] c_STEP = 14'(g_TRI_STEP);

  logic signed [13:0] tri_q, tri_d, nxt_val;
  logic               dir_q, dir_d, nxt_dir, flip; // dir: 0 = up

  // Flip direction once outside the limit, then step; commit only on adv_i.
  always_comb begin
    flip    = (tri_q > c_LIM) || (tri_q < -c_LIM);
    nxt_dir = dir_q ^ flip;
    nxt_val = nxt_dir ? (tri_q - c_STEP) : (tri_q + c_STEP);
    tri_d   = tri_q;
    dir_d   = dir_q;
    if (adv_i) begin
      tri_d = nxt_val;
      dir_d = nxt_dir;
    end
    word_o = '0;
    case (mode_i)
      MODE_TRI:   word_o = nxt_val;
      MODE_FIXED: word_o = g_FIXED_PATTERN;
      default:    word_o = '0;
    endcase
  end

  // Triangle state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tri_q <= '0;
      dir_q <= 1'b0;
    end else begin
      tri_q <= tri_d;
      dir_q <= dir_d;
    end
  end
endmodule

// File: rtl/fmc_adc_serdes_tx.sv
// LTC2174-style 2-lane serializer: per channel, odd bits on outa, even bits
// on outb, 8-cycle frame with fr high for the first four bit slots.
module fmc_adc_serdes_tx
  import fmc_adc_serdes_tx_pkg::*;
#(
  parameter int          g_NB_CHANNELS   = 4,
  parameter int          g_TRI_STEP      = 8,
  parameter int          g_TRI_LIMIT     = 400,
  parameter logic [13:0] g_FIXED_PATTERN = 14'h1555
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  fmc_adc_serdes_tx_if.slave bus
);
  localparam logic [2:0] c_LAST = 3'(c_BITS_PER_FRAME - 1);

  t_tx_state state_q, state_d;
  logic [2:0] cnt_q, cnt_d;   // bit slot currently on the output pins
  logic [g_NB_CHANNELS-1:0][c_SAMPLE_WIDTH-1:0] sr_q, sr_d, hold_q, hold_d, src;
  logic [g_NB_CHANNELS-1:0] outa_q, outa_d, outb_q, outb_d;
  logic [15:0] underrun_q, underrun_d;
  logic        fr_q, fr_d, load, ready, adv;
  t_tx_mode    mode;
  t_word       pat_word;

  assign mode  = t_tx_mode'(bus.mode_i);
  assign load  = bus.en_i && ((state_q == IDLE) || (cnt_q == c_LAST));
  assign ready = load && (mode == MODE_EXT);
  assign adv   = load && (mode == MODE_TRI);

  fmc_adc_pattern_gen #(
    .g_TRI_STEP      (g_TRI_STEP),
    .g_TRI_LIMIT     (g_TRI_LIMIT),
    .g_FIXED_PATTERN (g_FIXED_PATTERN)
  ) u_pat (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .adv_i   (adv),
    .mode_i  (mode),
    .word_o  (pat_word)
  );

  // Frame sequencing, held external word and underrun accounting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    if (load) begin
      state_d = TX;
      cnt_d   = '0;
    end else if (state_q == TX) begin
      if (cnt_q == c_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    if (ready) begin
      if (bus.sample_valid_i) hold_d = bus.sample_i;
      else if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
    end
    fr_d = (state_d == TX) && (cnt_d < 3'd4);
  end

  // Per-channel lane shifters: top two bits go out, the rest shift up by two.
  for (genvar g = 0; g < g_NB_CHANNELS; g++) begin : g_lane
    assign src[g]    = (mode != MODE_EXT) ? pat_word :
                       (bus.sample_valid_i ? bus.sample_i[g] : hold_q[g]);
    assign sr_d[g]   = load ? {src[g][11:0], 2'b00} : {sr_q[g][11:0], 2'b00};
    assign outa_d[g] = load ? src[g][13] :
                       ((state_q == TX) && (cnt_q < 3'd6)) ? sr_q[g][13] : 1'b0;
    assign outb_d[g] = load ? src[g][12] :
                       ((state_q == TX) && (cnt_q < 3'd6)) ? sr_q[g][12] : 1'b0;
  end

  // State and registered serial outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      hold_q     <= '0;
      outa_q     <= '0;
      outb_q     <= '0;
      fr_q       <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      outa_q     <= outa_d;
      outb_q     <= outb_d;
      fr_q       <= fr_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.sample_ready_o = ready;
  assign bus.fr_o           = fr_q;
  assign bus.outa_o         = outa_q;
  assign bus.outb_o         = outb_q;
  assign bus.underrun_cnt_o = underrun_q;
  assign bus.busy_o         = (state_q == TX);
endmodule
